// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - multi-channel clock divider / clock-enable generator
// Optional phase-align input I_SYNC is built only with CLKDIV_SYNC_START_EN defined.
module clkdiv_multi #(
   parameter int NCH     = 2,
   parameter int CNT_W   = 24,
   parameter int DEF_DIV = 4
) (
   input  logic               I_CLK,
   input  logic               rst_n,
`ifdef CLKDIV_SYNC_START_EN
   input  logic               I_SYNC,
`endif
   input  logic [NCH-1:0]       I_EN,
   input  logic [NCH*CNT_W-1:0] I_DIV,
   input  logic [NCH-1:0]       I_LOAD,
   output logic [NCH-1:0]       O_CLK,
   output logic [NCH-1:0]       O_TICK,
   output logic [NCH-1:0]       O_PEND
);

   localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE_W     = CNT_W'(1);

   logic w_sync;
`ifdef CLKDIV_SYNC_START_EN
   assign w_sync = I_SYNC;
`else
   assign w_sync = 1'b0;
`endif

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : g_ch
         logic [CNT_W-1:0] r_cnt;
         logic [CNT_W-1:0] r_act;
         logic [CNT_W-1:0] r_sh;
         logic             r_pend;
         logic             r_clk;
         logic             r_tick;

         logic [CNT_W-1:0] w_div;
         logic [CNT_W-1:0] w_last;
         logic             w_tog;
         logic             w_bnd;

         assign w_div  = I_DIV[g*CNT_W +: CNT_W];
         // A divisor of 0 counts like 1, so the last count is 0 in both cases.
         assign w_last = (r_act == '0) ? '0 : (r_act - ONE_W);
         assign w_tog  = (r_cnt == w_last);
         assign w_bnd  = w_tog & r_clk;

         always_ff @(posedge I_CLK) begin
            if (!rst_n) begin
               r_cnt  <= '0;
               r_act  <= DEF_DIV_W;
               r_sh   <= '0;
               r_pend <= 1'b0;
               r_clk  <= 1'b0;
               r_tick <= 1'b0;
            end else if (w_sync || !I_EN[g]) begin
               // Parked (or phase-aligned): hold low, adopt any divisor immediately.
               r_cnt  <= '0;
               r_clk  <= 1'b0;
               r_tick <= 1'b0;
               if (I_LOAD[g]) begin
                  r_act  <= w_div;
                  r_pend <= 1'b0;
               end else if (r_pend) begin
                  r_act  <= r_sh;
                  r_pend <= 1'b0;
               end
            end else begin
               if (w_tog) begin
                  r_cnt  <= '0;
                  r_clk  <= ~r_clk;
                  r_tick <= ~r_clk;
               end else begin
                  r_cnt  <= r_cnt + ONE_W;
                  r_tick <= 1'b0;
               end
               // Reload only at the falling toggle so high and low phases always match.
               if (I_LOAD[g]) begin
                  if (w_bnd) begin
                     r_act  <= w_div;
                     r_pend <= 1'b0;
                  end else begin
                     r_sh   <= w_div;
                     r_pend <= 1'b1;
                  end
               end else if (w_bnd && r_pend) begin
                  r_act  <= r_sh;
                  r_pend <= 1'b0;
               end
            end
         end

         assign O_CLK[g]  = r_clk;
         assign O_TICK[g] = r_tick;
         assign O_PEND[g] = r_pend;
      end
   endgenerate

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - self-checking bench for clkdiv_multi
// Reference model tracks position within the whole period rather than a half-period counter.
module tb_clkdiv_multi;

   localparam int NCH   = 2;
   localparam int CNT_W = 24;
   localparam int DEFD  = 4;

   logic               clk;
   logic               rst_n;
   logic [NCH-1:0]       en;
   logic [NCH*CNT_W-1:0] div;
   logic [NCH-1:0]       load;
   logic                 sync;
   logic [NCH-1:0]       o_clk;
   logic [NCH-1:0]       o_tick;
   logic [NCH-1:0]       o_pend;

   int checks = 0;
   int errors = 0;

   // model state per channel
   int unsigned m_k    [NCH];
   int unsigned m_act  [NCH];
   int unsigned m_sh   [NCH];
   logic        m_pend [NCH];
   logic        m_clk  [NCH];
   logic        m_tick [NCH];

   clkdiv_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(DEFD)) dut (
      .I_CLK  (clk),
      .rst_n  (rst_n),
`ifdef CLKDIV_SYNC_START_EN
      .I_SYNC (sync),
`endif
      .I_EN   (en),
      .I_DIV  (div),
      .I_LOAD (load),
      .O_CLK  (o_clk),
      .O_TICK (o_tick),
      .O_PEND (o_pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned n_of(input int c);
      return (m_act[c] == 0) ? 1 : m_act[c];
   endfunction

   function automatic logic next_is_bnd(input int c);
      return (m_k[c] + 1) == 2 * n_of(c);
   endfunction

   task automatic model_update();
      logic use_sync;
`ifdef CLKDIV_SYNC_START_EN
      use_sync = sync;
`else
      use_sync = 1'b0;
`endif
      for (int c = 0; c < NCH; c++) begin
         int unsigned d;
         int unsigned n;
         logic bnd;
         d = div[c*CNT_W +: CNT_W];
         n = n_of(c);
         if (!rst_n) begin
            m_k[c] = 0; m_act[c] = DEFD; m_sh[c] = 0; m_pend[c] = 0;
            m_clk[c] = 0; m_tick[c] = 0;
         end else if (use_sync || !en[c]) begin
            m_k[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
            if (load[c]) begin
               m_act[c] = d; m_pend[c] = 0;
            end else if (m_pend[c]) begin
               m_act[c] = m_sh[c]; m_pend[c] = 0;
            end
         end else begin
            m_k[c]    = m_k[c] + 1;
            m_tick[c] = (m_k[c] == n);
            bnd       = (m_k[c] == 2 * n);
            if (bnd) m_k[c] = 0;
            m_clk[c]  = (m_k[c] >= n);
            if (load[c]) begin
               if (bnd) begin
                  m_act[c] = d; m_pend[c] = 0;
               end else begin
                  m_sh[c] = d; m_pend[c] = 1;
               end
            end else if (bnd && m_pend[c]) begin
               m_act[c] = m_sh[c]; m_pend[c] = 0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Apply current inputs for one edge, compare against the model, then clear strobes.
   task automatic step();
      logic [NCH-1:0] e_clk, e_tick, e_pend;
      model_update();
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
         e_clk[c] = m_clk[c]; e_tick[c] = m_tick[c]; e_pend[c] = m_pend[c];
      end
      chk("o_clk", o_clk, e_clk);
      chk("o_tick", o_tick, e_tick);
      chk("o_pend", o_pend, e_pend);
      load = '0;
      sync = 1'b0;
   endtask

   task automatic set_div(input int c, input int unsigned v);
      div[c*CNT_W +: CNT_W] = CNT_W'(v);
   endtask

   initial begin
      rst_n = 1'b0; en = '0; div = '0; load = '0; sync = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         m_k[c] = 0; m_act[c] = DEFD; m_sh[c] = 0; m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end
      @(negedge clk);

      // 1: reset then default divide-by-8
      for (int i = 0; i < 3; i++) step();
      chk("reset_clk", o_clk, 2'b00);
      chk("reset_pend", o_pend, 2'b00);
      rst_n = 1'b1; en = 2'b11;
      for (int e = 1; e <= 20; e++) begin
         step();
         chk("t1_clk0", o_clk[0], ((e % 8) >= 4));
         chk("t1_tick0", o_tick[0], (e == 4 || e == 12 || e == 20));
      end

      // 2: load 2 during the high phase, applied at the falling boundary
      for (int i = 0; i < 40 && !(m_clk[0] && !next_is_bnd(0)); i++) step();
      set_div(0, 2); load = 2'b01;
      step();
      chk("t2_pend", o_pend[0], 1'b1);
      for (int i = 0; i < 16; i++) step();

      // 3: divisor 0 loaded while disabled behaves as 1
      en = 2'b10; step();
      set_div(0, 0); load = 2'b01; step();
      en = 2'b11;
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("t3_clk0", o_clk[0], i[0]);
         chk("t3_tick0", o_tick[0], i[0]);
      end

      // 4: two loads before a boundary, then a load on the boundary itself
      en = 2'b10; set_div(0, 4); load = 2'b01; step();
      en = 2'b11; step();
      set_div(0, 6); load = 2'b01; step();
      set_div(0, 3); load = 2'b01; step();
      for (int i = 0; i < 30; i++) step();
      for (int i = 0; i < 40 && !next_is_bnd(0); i++) step();
      set_div(0, 5); load = 2'b01; step();
      chk("t4_bnd_pend", o_pend[0], 1'b0);
      for (int i = 0; i < 22; i++) step();

      // 5: drop ch1 enable in its high phase, re-enable, then mid-period reset
      for (int i = 0; i < 40 && !m_clk[1]; i++) step();
      en = 2'b01; step();
      chk("t5_park_clk1", o_clk[1], 1'b0);
      chk("t5_park_tick1", o_tick[1], 1'b0);
      en = 2'b11;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("t5_rise_clk1", o_clk[1], (i == 4));
      end
      step(); step();
      rst_n = 1'b0; step();
      chk("t5_rst_clk", o_clk, 2'b00);
      chk("t5_rst_tick", o_tick, 2'b00);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) step();

`ifdef CLKDIV_SYNC_START_EN
      // 6: phase-align ch0 N=3 and ch1 N=5
      en = 2'b00; set_div(0, 3); set_div(1, 5); load = 2'b11; step();
      en = 2'b11;
      for (int i = 0; i < 17; i++) step();
      sync = 1'b1; step();
      chk("t6_sync_clk", o_clk, 2'b00);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("t6_clk0", o_clk[0], (i >= 3));
         chk("t6_clk1", o_clk[1], (i >= 5));
      end
`endif

      // 7: randomized traffic
      for (int i = 0; i < 800; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         for (int c = 0; c < NCH; c++) begin
            en[c]   = ($urandom_range(0, 9) != 0);
            load[c] = ($urandom_range(0, 5) == 0);
            set_div(c, $urandom_range(0, 6));
         end
`ifdef CLKDIV_SYNC_START_EN
         sync = ($urandom_range(0, 96) == 0);
`endif
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
